// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 4-stage 8-bit core: drives inter-stage
// register enables/flushes for load-use, taken branches, memory waits, HALT and timeout.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  ex_valid,
    input  logic                  ex_read_mem,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_branch_taken,
    input  logic                  ex_halt,
    input  logic                  mem_busy,
    input  logic                  resume,
    output logic                  pc_en,
    output logic                  pc_load,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  halted,
    output logic                  err,
    output logic [15:0]           stall_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;
    localparam logic [1:0] ST_ERR      = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic pc_en_c, pc_load_c, if_id_en_c, if_id_flush_c;
    logic id_ex_en_c, id_ex_flush_c, ex_mem_en_c, halted_c, err_c;

    assign load_use = id_valid & ex_valid & ex_read_mem &
                      ((id_use_a & (id_src_a == ex_dst)) |
                       (id_use_b & (id_src_b == ex_dst)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_en_c       = 1'b0;
        pc_load_c     = 1'b0;
        if_id_en_c    = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_en_c    = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_mem_en_c   = 1'b0;
        halted_c      = 1'b0;
        err_c         = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    // Whole pipe frozen; wait_cnt is 0 in RUN so the first busy cycle lands on 1.
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d     = ST_RUN;
                    wait_cnt_d  = 8'd0;
                    pc_en_c     = 1'b1;
                    if_id_en_c  = 1'b1;
                    id_ex_en_c  = 1'b1;
                    ex_mem_en_c = 1'b1;
                    if (ex_branch_taken) begin
                        pc_load_c     = 1'b1;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (ex_valid && ex_halt) begin
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                        state_d       = ST_HALT;
                    end else if (load_use) begin
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                halted_c   = 1'b1;
                wait_cnt_d = 8'd0;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                err_c = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en_c &&
            (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced quiet for as long as reset is held, independent of the clock.
    assign pc_en       = pc_en_c & ~reset;
    assign pc_load     = pc_load_c & ~reset;
    assign if_id_en    = if_id_en_c & ~reset;
    assign if_id_flush = if_id_flush_c & ~reset;
    assign id_ex_en    = id_ex_en_c & ~reset;
    assign id_ex_flush = id_ex_flush_c & ~reset;
    assign ex_mem_en   = ex_mem_en_c & ~reset;
    assign halted      = halted_c & ~reset;
    assign err         = err_c & ~reset;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected outputs are queued as each cycle's
// stimulus is applied and popped/compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       id_valid, id_use_a, id_use_b;
        logic [2:0] id_src_a, id_src_b;
        logic       ex_valid, ex_read_mem;
        logic [2:0] ex_dst;
        logic       br, hlt, busy, res;
    } stim_t;

    typedef struct packed {
        logic [8:0]  o;
        logic [15:0] sc;
    } exp_t;

    // {pc_en,pc_load,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,halted,err}
    localparam logic [8:0] O_RUN  = 9'b101010100;
    localparam logic [8:0] O_LU   = 9'b000011100;
    localparam logic [8:0] O_BR   = 9'b111111100;
    localparam logic [8:0] O_BUSY = 9'b000000000;
    localparam logic [8:0] O_HALT = 9'b000000010;
    localparam logic [8:0] O_ERR  = 9'b000000001;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_use_a, id_use_b;
    logic [2:0] id_src_a, id_src_b, ex_dst;
    logic ex_valid, ex_read_mem, ex_branch_taken, ex_halt, mem_busy, resume;
    logic pc_en, pc_load, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted, err;
    logic [15:0] stall_cnt;
    logic [8:0] outs;

    int checks = 0;
    int passed = 0;
    exp_t scb[$];

    always #5 clk = ~clk;

    assign outs = {pc_en, pc_load, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, halted, err};

    pipe_hazard_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .ex_valid(ex_valid), .ex_read_mem(ex_read_mem), .ex_dst(ex_dst),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
        .mem_busy(mem_busy), .resume(resume),
        .pc_en(pc_en), .pc_load(pc_load), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .halted(halted), .err(err), .stall_cnt(stall_cnt)
    );

    function automatic stim_t mk(input logic idv, input logic ua, input logic ub,
                                 input logic [2:0] sa, input logic [2:0] sbx,
                                 input logic exv, input logic rm, input logic [2:0] dst,
                                 input logic br, input logic hl, input logic bz,
                                 input logic rs);
        stim_t s;
        s.id_valid = idv; s.id_use_a = ua; s.id_use_b = ub;
        s.id_src_a = sa;  s.id_src_b = sbx;
        s.ex_valid = exv; s.ex_read_mem = rm; s.ex_dst = dst;
        s.br = br; s.hlt = hl; s.busy = bz; s.res = rs;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.id_valid; id_use_a = s.id_use_a; id_use_b = s.id_use_b;
        id_src_a = s.id_src_a; id_src_b = s.id_src_b;
        ex_valid = s.ex_valid; ex_read_mem = s.ex_read_mem; ex_dst = s.ex_dst;
        ex_branch_taken = s.br; ex_halt = s.hlt; mem_busy = s.busy; resume = s.res;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        apply(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
        scb.push_back('{9'b0, 16'd0});
        #2;
        e = scb.pop_front();
        checks++;
        if (outs !== e.o) $display("FAIL reset_pre_clk outs got %b want %b", outs, e.o);
        else passed++;
        scb.push_back('{9'b0, 16'd0});
        @(negedge clk);
        e = scb.pop_front();
        checks++;
        if ({outs, stall_cnt} !== {e.o, e.sc})
            $display("FAIL reset_held outs/cnt got %b/%0d want %b/%0d", outs, stall_cnt, e.o, e.sc);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        scb.push_back('{O_RUN, 16'd0});
        @(negedge clk);
        e = scb.pop_front();
        checks++;
        if ({outs, stall_cnt} !== {e.o, e.sc})
            $display("FAIL reset_release outs/cnt got %b/%0d want %b/%0d", outs, stall_cnt, e.o, e.sc);
        else passed++;
    endtask

    task automatic test_load_use();
        stim_t st[7];
        logic [8:0] eo[7];
        logic [15:0] es[7];
        exp_t e;
        st = '{mk(1,1,0,2,0, 1,1,2, 0,0,0,0), mk(1,1,0,2,0, 0,0,0, 0,0,0,0),
               mk(1,0,1,5,0, 1,1,0, 0,0,0,0), mk(1,0,0,0,0, 1,1,0, 0,0,0,0),
               mk(1,1,1,3,3, 0,1,3, 0,0,0,0), mk(1,1,1,4,5, 1,1,6, 0,0,0,0),
               mk(0,1,0,2,0, 1,1,2, 0,0,0,0)};
        eo = '{O_LU, O_RUN, O_LU, O_RUN, O_RUN, O_RUN, O_RUN};
        es = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            scb.push_back('{eo[i], es[i]});
            @(negedge clk);
            e = scb.pop_front();
            checks++;
            if (outs !== e.o) $display("FAIL load_use[%0d] outs got %b want %b", i, outs, e.o);
            else passed++;
            checks++;
            if (stall_cnt !== e.sc) $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.sc);
            else passed++;
        end
    endtask

    task automatic test_branch();
        stim_t st[2];
        logic [8:0] eo[2];
        logic [15:0] es[2];
        exp_t e;
        st = '{mk(1,1,0,2,0, 1,1,2, 1,0,0,0), mk(0,0,0,0,0, 0,0,0, 0,0,0,0)};
        eo = '{O_BR, O_RUN};
        es = '{16'd2, 16'd2};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            scb.push_back('{eo[i], es[i]});
            @(negedge clk);
            e = scb.pop_front();
            checks++;
            if (outs !== e.o) $display("FAIL branch[%0d] outs got %b want %b", i, outs, e.o);
            else passed++;
            checks++;
            if (stall_cnt !== e.sc) $display("FAIL branch[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.sc);
            else passed++;
        end
    endtask

    task automatic test_mem_busy();
        stim_t st[5];
        logic [8:0] eo[5];
        logic [15:0] es[5];
        exp_t e;
        st = '{mk(0,0,0,0,0, 1,0,0, 1,0,1,0), mk(0,0,0,0,0, 1,0,0, 1,0,1,0),
               mk(0,0,0,0,0, 1,0,0, 1,0,1,0), mk(0,0,0,0,0, 1,0,0, 1,0,0,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,0,0)};
        eo = '{O_BUSY, O_BUSY, O_BUSY, O_BR, O_RUN};
        es = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd5};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            scb.push_back('{eo[i], es[i]});
            @(negedge clk);
            e = scb.pop_front();
            checks++;
            if (outs !== e.o) $display("FAIL mem_busy[%0d] outs got %b want %b", i, outs, e.o);
            else passed++;
            checks++;
            if (stall_cnt !== e.sc) $display("FAIL mem_busy[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.sc);
            else passed++;
        end
    endtask

    task automatic test_halt();
        stim_t st[7];
        logic [8:0] eo[7];
        logic [15:0] es[7];
        exp_t e;
        st = '{mk(0,0,0,0,0, 0,0,0, 0,1,0,0), mk(1,1,0,1,0, 1,0,3, 0,1,0,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,0,0), mk(0,0,0,0,0, 0,0,0, 0,0,0,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,0,1), mk(0,0,0,0,0, 0,0,0, 0,0,0,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,0,1)};
        eo = '{O_RUN, O_LU, O_HALT, O_HALT, O_HALT, O_RUN, O_RUN};
        es = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd6, 16'd6, 16'd6};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            scb.push_back('{eo[i], es[i]});
            @(negedge clk);
            e = scb.pop_front();
            checks++;
            if (outs !== e.o) $display("FAIL halt[%0d] outs got %b want %b", i, outs, e.o);
            else passed++;
            checks++;
            if (stall_cnt !== e.sc) $display("FAIL halt[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.sc);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        stim_t st[7];
        logic [8:0] eo[7];
        logic [15:0] es[7];
        exp_t e;
        st = '{mk(0,0,0,0,0, 0,0,0, 0,0,1,0), mk(0,0,0,0,0, 0,0,0, 0,0,1,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,1,0), mk(0,0,0,0,0, 0,0,0, 0,0,1,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,1,0), mk(0,0,0,0,0, 0,0,0, 0,0,0,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,0,1)};
        eo = '{O_BUSY, O_BUSY, O_BUSY, O_BUSY, O_ERR, O_ERR, O_ERR};
        es = '{16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd10, 16'd10};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            scb.push_back('{eo[i], es[i]});
            @(negedge clk);
            e = scb.pop_front();
            checks++;
            if (outs !== e.o) $display("FAIL timeout[%0d] outs got %b want %b", i, outs, e.o);
            else passed++;
            checks++;
            if (stall_cnt !== e.sc) $display("FAIL timeout[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.sc);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        stim_t st[6];
        logic [8:0] eo[6];
        logic [15:0] es[6];
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b1;
        apply(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
        @(posedge clk); #1;
        reset = 1'b0;
        // rows 0-1 enter MEM_WAIT, reset hits mid-wait, rows 2-5 run afterwards
        st = '{mk(0,0,0,0,0, 0,0,0, 0,0,1,0), mk(0,0,0,0,0, 0,0,0, 0,0,1,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,1,0), mk(0,0,0,0,0, 0,0,0, 0,0,1,0),
               mk(0,0,0,0,0, 0,0,0, 0,0,1,0), mk(0,0,0,0,0, 0,0,0, 0,0,0,0)};
        eo = '{O_BUSY, O_BUSY, O_BUSY, O_BUSY, O_BUSY, O_RUN};
        es = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            if (i == 2) begin
                apply(mk(0,0,0,0,0, 0,0,0, 0,0,1,0));
                #1 reset = 1'b1;
                scb.push_back('{9'b0, 16'd0});
                #1;
                e = scb.pop_front();
                checks++;
                if ({outs, stall_cnt} !== {e.o, e.sc})
                    $display("FAIL async_reset outs/cnt got %b/%0d want %b/%0d", outs, stall_cnt, e.o, e.sc);
                else passed++;
                apply(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
                reset = 1'b0;
                scb.push_back('{O_RUN, 16'd0});
                @(negedge clk);
                e = scb.pop_front();
                checks++;
                if ({outs, stall_cnt} !== {e.o, e.sc})
                    $display("FAIL after_reset outs/cnt got %b/%0d want %b/%0d", outs, stall_cnt, e.o, e.sc);
                else passed++;
                @(posedge clk); #1;
                apply(st[i]);
            end
            scb.push_back('{eo[i], es[i]});
            @(negedge clk);
            e = scb.pop_front();
            checks++;
            if (outs !== e.o) $display("FAIL async[%0d] outs got %b want %b", i, outs, e.o);
            else passed++;
            checks++;
            if (stall_cnt !== e.sc) $display("FAIL async[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.sc);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_halt();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
